// File: rtl/raster_csr_agent_pkg.sv
`default_nettype none
// ============================================================================
// Module   : raster_csr_agent_pkg
// Purpose  : Shared raster types for the core-side stamp receiver: the stamp
//            bundle format delivered by the raster unit, the per-lane CSR
//            image held by the core, CSR offsets and the POS_MASK packer.
// Contents : raster_stamp_t, raster_csrs_t, RASTER_CSR_* offsets,
//            raster_pack_pos_mask()
// Revision : 1.0 - initial release
// ============================================================================
package raster_csr_agent_pkg;

    // Raster dimension and primitive-id widths. Quad position fields are one
    // bit narrower than the raster dimension.
    localparam int RASTER_DIM_BITS    = 12;
    localparam int RASTER_PID_BITS    = 8;
    localparam int RASTER_NUM_BCOORDS = 4;

    // CSR offsets as decoded by the core CSR unit.
    localparam logic [3:0] RASTER_CSR_POS_MASK  = 4'd0;
    localparam logic [3:0] RASTER_CSR_BCOORD_X0 = 4'd1;
    localparam logic [3:0] RASTER_CSR_BCOORD_Y0 = 4'd5;
    localparam logic [3:0] RASTER_CSR_BCOORD_Z0 = 4'd9;
    localparam int         RASTER_CSR_COUNT     = 13;

    // One stamp (quad) as produced by the raster unit.
    typedef struct packed {
        logic [RASTER_NUM_BCOORDS-1:0][31:0] bcoord_z;
        logic [RASTER_NUM_BCOORDS-1:0][31:0] bcoord_y;
        logic [RASTER_NUM_BCOORDS-1:0][31:0] bcoord_x;
        logic [RASTER_PID_BITS-1:0]          pid;
        logic [RASTER_DIM_BITS-2:0]          pos_y;
        logic [RASTER_DIM_BITS-2:0]          pos_x;
        logic [3:0]                          mask;
    } raster_stamp_t;

    // Per-lane CSR image. Field order is chosen so that viewing the struct
    // as a packed array of 32-bit words puts word N at CSR offset N.
    typedef struct packed {
        logic [RASTER_NUM_BCOORDS-1:0][31:0] bcoord_z;
        logic [RASTER_NUM_BCOORDS-1:0][31:0] bcoord_y;
        logic [RASTER_NUM_BCOORDS-1:0][31:0] bcoord_x;
        logic [31:0]                         pos_mask;
    } raster_csrs_t;

    localparam int RASTER_STAMP_W = $bits(raster_stamp_t);

    // POS_MASK layout: zero-extended {pos_y, pos_x, mask}, mask in [3:0].
    function automatic logic [31:0] raster_pack_pos_mask(
        input logic [RASTER_DIM_BITS-2:0] pos_x,
        input logic [RASTER_DIM_BITS-2:0] pos_y,
        input logic [3:0]                 mask
    );
        return 32'({pos_y, pos_x, mask});
    endfunction

endpackage
`default_nettype wire

// File: rtl/raster_csr_agent_if.sv
`default_nettype none
// ============================================================================
// Module   : raster_csr_agent_if
// Purpose  : Bus bundle between the raster unit / core CSR unit (master side)
//            and the raster CSR agent (slave side).
// Signals  : stamp_* (bundle stream), csr_req_* / csr_rsp_* (CSR reads),
//            release_* (slot free), slot_full (occupancy)
// Revision : 1.0 - initial release
// ============================================================================
interface raster_csr_agent_if
    import raster_csr_agent_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int NUM_SLOTS = 4
);
    localparam int WID_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic                                stamp_valid;
    logic [WID_W-1:0]                    stamp_wid;
    logic [NUM_LANES-1:0]                stamp_tmask;
    logic [NUM_LANES*RASTER_STAMP_W-1:0] stamp_data;
    logic                                stamp_ready;

    logic                                csr_req_valid;
    logic [WID_W-1:0]                    csr_req_wid;
    logic [NUM_LANES-1:0]                csr_req_tmask;
    logic [3:0]                          csr_req_addr;
    logic                                csr_rsp_valid;
    logic [NUM_LANES*32-1:0]             csr_rsp_data;

    logic                                release_valid;
    logic [WID_W-1:0]                    release_wid;

    logic [NUM_SLOTS-1:0]                slot_full;

    modport master (
        output stamp_valid, stamp_wid, stamp_tmask, stamp_data,
        input  stamp_ready,
        output csr_req_valid, csr_req_wid, csr_req_tmask, csr_req_addr,
        input  csr_rsp_valid, csr_rsp_data,
        output release_valid, release_wid,
        input  slot_full
    );

    modport slave (
        input  stamp_valid, stamp_wid, stamp_tmask, stamp_data,
        output stamp_ready,
        input  csr_req_valid, csr_req_wid, csr_req_tmask, csr_req_addr,
        output csr_rsp_valid, csr_rsp_data,
        input  release_valid, release_wid,
        output slot_full
    );

endinterface
`default_nettype wire

// File: rtl/raster_csr_agent_bank.sv
`default_nettype none
// ============================================================================
// Module   : raster_csr_bank
// Purpose  : One lane's CSR storage, NUM_SLOTS entries of raster_csrs_t.
//            One write port, one registered read port. A read and a write to
//            the same entry in one cycle returns the previous contents.
// Ports    : clk; wr_en/wr_addr/wr_data; rd_en/rd_addr; rd_data (1-cycle)
// Revision : 1.0 - initial release
// ============================================================================
module raster_csr_bank
    import raster_csr_agent_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int ADDR_W    = 2
) (
    input  wire logic         clk,
    input  wire logic         wr_en,
    input  wire logic [ADDR_W-1:0] wr_addr,
    input  raster_csrs_t      wr_data,
    input  wire logic         rd_en,
    input  wire logic [ADDR_W-1:0] rd_addr,
    output raster_csrs_t      rd_data
);

    // Storage is deliberately not reset; slot occupancy is tracked outside.
    raster_csrs_t r_mem [NUM_SLOTS];
    raster_csrs_t r_rd_data;

    // Both ports use non-blocking updates, so a same-address read in the
    // write cycle naturally observes the old entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/raster_csr_agent.sv
`default_nettype none
// ============================================================================
// Module   : raster_csr_agent
// Purpose  : Core-side receiver for raster stamps. Holds one stamp bundle per
//            warp slot, serves raster CSR reads with 1-cycle latency and
//            frees a slot when its warp releases it.
// Ports    : clk, reset (sync, active-high)
//            bus (raster_csr_agent_if.slave):
//              stamp_valid/wid/tmask/data -> stamp_ready
//              csr_req_valid/wid/tmask/addr -> csr_rsp_valid/data
//              release_valid/wid
//              slot_full (per-slot occupancy)
// Notes    : Raster dimension / primitive-id widths come from the package.
// Revision : 1.0 - initial release
// ============================================================================
module raster_csr_agent
    import raster_csr_agent_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int NUM_SLOTS = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    raster_csr_agent_if.slave bus
);

    localparam int WID_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    localparam logic [0:0] SLOT_EMPTY = 1'b0;
    localparam logic [0:0] SLOT_FULL  = 1'b1;

    // ------------------------------------------------------------------
    // Slot state and stamp handshake
    // ------------------------------------------------------------------
    logic [NUM_SLOTS-1:0] r_slot_state;
    logic                 w_release_hit;
    logic                 w_stamp_ready;
    logic                 w_accept;

    // A release to the slot being written frees it in the same cycle, so the
    // new bundle can be taken without a bubble. stamp_valid is not involved.
    assign w_release_hit = bus.release_valid && (bus.release_wid == bus.stamp_wid);
    assign w_stamp_ready = !reset &&
                           ((r_slot_state[bus.stamp_wid] == SLOT_EMPTY) || w_release_hit);
    assign w_accept      = bus.stamp_valid && w_stamp_ready;

    // Write takes priority over release so a same-cycle release+write of one
    // slot leaves it FULL. Releasing an EMPTY slot leaves it EMPTY.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_state <= {NUM_SLOTS{SLOT_EMPTY}};
        end else begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (w_accept && (bus.stamp_wid == WID_W'(s))) begin
                    r_slot_state[s] <= SLOT_FULL;
                end else if (bus.release_valid && (bus.release_wid == WID_W'(s))) begin
                    r_slot_state[s] <= SLOT_EMPTY;
                end
            end
        end
    end

    assign bus.stamp_ready = w_stamp_ready;
    assign bus.slot_full   = r_slot_state;

    // ------------------------------------------------------------------
    // Request stage: slot occupancy is captured with the request so the
    // response reflects the state at request time.
    // ------------------------------------------------------------------
    logic                 r_rsp_valid;
    logic [NUM_LANES-1:0] r_req_tmask;
    logic [3:0]           r_req_addr;
    logic                 r_req_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_req_tmask <= '0;
            r_req_addr  <= '0;
            r_req_hit   <= 1'b0;
        end else begin
            r_rsp_valid <= bus.csr_req_valid;
            r_req_tmask <= bus.csr_req_tmask;
            r_req_addr  <= bus.csr_req_addr;
            r_req_hit   <= (r_slot_state[bus.csr_req_wid] == SLOT_FULL);
        end
    end

    logic w_addr_ok;
    assign w_addr_ok = (r_req_addr < 4'(RASTER_CSR_COUNT));

    // ------------------------------------------------------------------
    // Per-lane storage and response select
    // ------------------------------------------------------------------
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        raster_stamp_t                         w_stamp;
        raster_csrs_t                          w_wr_csrs;
        raster_csrs_t                          w_rd_csrs;
        logic [RASTER_CSR_COUNT-1:0][31:0]     w_rd_words;
        logic                                  unused_pid;

        assign w_stamp    = bus.stamp_data[l*RASTER_STAMP_W +: RASTER_STAMP_W];
        assign unused_pid = ^w_stamp.pid;

        // Lanes without a stamp store an empty quad mask.
        assign w_wr_csrs.pos_mask = raster_pack_pos_mask(
                                        w_stamp.pos_x, w_stamp.pos_y,
                                        bus.stamp_tmask[l] ? w_stamp.mask : 4'h0);
        assign w_wr_csrs.bcoord_x = w_stamp.bcoord_x;
        assign w_wr_csrs.bcoord_y = w_stamp.bcoord_y;
        assign w_wr_csrs.bcoord_z = w_stamp.bcoord_z;

        raster_csr_bank #(
            .NUM_SLOTS (NUM_SLOTS),
            .ADDR_W    (WID_W)
        ) u_bank (
            .clk     (clk),
            .wr_en   (w_accept),
            .wr_addr (bus.stamp_wid),
            .wr_data (w_wr_csrs),
            .rd_en   (bus.csr_req_valid),
            .rd_addr (bus.csr_req_wid),
            .rd_data (w_rd_csrs)
        );

        // Word N of the CSR image is CSR offset N.
        assign w_rd_words = w_rd_csrs;

        assign bus.csr_rsp_data[l*32 +: 32] =
            (r_rsp_valid && r_req_tmask[l] && r_req_hit && w_addr_ok)
                ? w_rd_words[r_req_addr] : 32'h0;
    end

    assign bus.csr_rsp_valid = r_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_raster_csr_agent.sv
`default_nettype none
// ============================================================================
// Module   : tb_raster_csr_agent
// Purpose  : Self-checking bench for raster_csr_agent. A driver applies
//            directed and random stimulus, keeps a behavioural model of the
//            warp slots and pushes expected CSR responses into a queue; a
//            monitor pops and compares whenever a response appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_raster_csr_agent;
    import raster_csr_agent_pkg::*;

    localparam int NL = 4;
    localparam int NS = 4;
    localparam int SW = RASTER_STAMP_W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    raster_csr_agent_if #(.NUM_LANES(NL), .NUM_SLOTS(NS)) bus ();

    raster_csr_agent #(.NUM_LANES(NL), .NUM_SLOTS(NS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          due;
        logic [127:0] data;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;
    bit   mon_en  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model: occupancy and the raw stamps per slot and lane.
    bit            m_full [NS];
    raster_stamp_t m_data [NS][NL];

    // Stimulus for the next cycle.
    logic          d_reset, d_sv, d_rv, d_relv, d_chk_zero;
    logic [1:0]    d_sw, d_rw, d_relw;
    logic [3:0]    d_stm, d_rtm, d_ra;
    raster_stamp_t d_st [NL];

    function automatic logic [31:0] model_csr(input raster_stamp_t s, input int addr);
        if (addr == 0)
            return 32'(s.mask) + (32'(s.pos_x) << 4) + (32'(s.pos_y) << (4 + RASTER_DIM_BITS - 1));
        else if (addr <= 4)
            return s.bcoord_x[addr-1];
        else if (addr <= 8)
            return s.bcoord_y[addr-5];
        else if (addr <= 12)
            return s.bcoord_z[addr-9];
        return 32'h0;
    endfunction

    function automatic raster_stamp_t rand_stamp();
        raster_stamp_t s;
        for (int k = 0; k < 4; k++) begin
            s.bcoord_x[k] = $urandom;
            s.bcoord_y[k] = $urandom;
            s.bcoord_z[k] = $urandom;
        end
        s.pid   = 8'($urandom);
        s.pos_x = (RASTER_DIM_BITS-1)'($urandom);
        s.pos_y = (RASTER_DIM_BITS-1)'($urandom);
        s.mask  = 4'($urandom);
        return s;
    endfunction

    task automatic idle();
        d_reset = 1'b0; d_sv = 1'b0; d_rv = 1'b0; d_relv = 1'b0; d_chk_zero = 1'b0;
        d_sw = 2'd0; d_rw = 2'd0; d_relw = 2'd0;
        d_stm = 4'h0; d_rtm = 4'h0; d_ra = 4'h0;
        for (int l = 0; l < NL; l++) d_st[l] = rand_stamp();
    endtask

    task automatic step();
        logic [NS-1:0]  exp_full;
        logic           exp_ready;
        logic [127:0]   exp_rsp;
        @(negedge clk);
        for (int s = 0; s < NS; s++) exp_full[s] = m_full[s];
        vectors++;
        if (bus.slot_full !== exp_full) begin
            errors++;
            $display("FAIL slot_full: got %b expected %b (cycle %0d)", bus.slot_full, exp_full, cyc);
        end
        if (d_chk_zero) begin
            vectors++;
            if (bus.csr_rsp_valid !== 1'b0 || bus.csr_rsp_data !== 128'h0) begin
                errors++;
                $display("FAIL rsp_after_reset: got valid=%b data=%h expected 0/0",
                         bus.csr_rsp_valid, bus.csr_rsp_data);
            end
        end
        reset             = d_reset;
        bus.stamp_valid   = d_sv;
        bus.stamp_wid     = d_sw;
        bus.stamp_tmask   = d_stm;
        for (int l = 0; l < NL; l++) bus.stamp_data[l*SW +: SW] = d_st[l];
        bus.csr_req_valid = d_rv;
        bus.csr_req_wid   = d_rw;
        bus.csr_req_tmask = d_rtm;
        bus.csr_req_addr  = d_ra;
        bus.release_valid = d_relv;
        bus.release_wid   = d_relw;
        #1;
        exp_ready = !d_reset && (!m_full[d_sw] || (d_relv && d_relw == d_sw));
        vectors++;
        if (bus.stamp_ready !== exp_ready) begin
            errors++;
            $display("FAIL stamp_ready: got %b expected %b (cycle %0d)", bus.stamp_ready, exp_ready, cyc);
        end
        // Response reflects state before this cycle's write/release.
        if (d_rv && !d_reset) begin
            exp_rsp = '0;
            for (int l = 0; l < NL; l++)
                if (d_rtm[l] && m_full[d_rw])
                    exp_rsp[l*32 +: 32] = model_csr(m_data[d_rw][l], int'(d_ra));
            q.push_back('{due: cyc + 1, data: exp_rsp});
        end
        if (d_reset) begin
            for (int s = 0; s < NS; s++) m_full[s] = 1'b0;
        end else begin
            if (d_relv) m_full[d_relw] = 1'b0;
            if (d_sv && exp_ready) begin
                m_full[d_sw] = 1'b1;
                for (int l = 0; l < NL; l++) begin
                    m_data[d_sw][l] = d_st[l];
                    if (!d_stm[l]) m_data[d_sw][l].mask = 4'h0;
                end
            end
        end
    endtask

    // Monitor: one response per request, exactly one cycle later.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.csr_rsp_valid) begin
                vectors++;
                if (q.size() == 0 || q[0].due != cyc) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got valid=1 data=%h expected no response (cycle %0d)",
                             bus.csr_rsp_data, cyc);
                end else begin
                    if (bus.csr_rsp_data !== q[0].data) begin
                        errors++;
                        $display("FAIL rsp_data: got %h expected %h (cycle %0d)",
                                 bus.csr_rsp_data, q[0].data, cyc);
                    end
                    void'(q.pop_front());
                end
            end else if (q.size() != 0 && q[0].due == cyc) begin
                vectors++;
                errors++;
                $display("FAIL rsp_missing: got valid=0 expected valid=1 data=%h (cycle %0d)",
                         q[0].data, cyc);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int s = 0; s < NS; s++) m_full[s] = 1'b0;
        idle();
        reset = 1'b1;
        bus.stamp_valid = 1'b0; bus.stamp_wid = '0; bus.stamp_tmask = '0; bus.stamp_data = '0;
        bus.csr_req_valid = 1'b0; bus.csr_req_wid = '0; bus.csr_req_tmask = '0; bus.csr_req_addr = '0;
        bus.release_valid = 1'b0; bus.release_wid = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Read of an empty slot after reset: all lanes zero.
        idle(); d_rv = 1; d_rw = 0; d_rtm = 4'hF; d_ra = 0; step();

        // Known stamp into wid1 lane0, then read POS_MASK and BCOORD_Y1.
        idle(); d_sv = 1; d_sw = 1; d_stm = 4'hF;
        d_st[0].pos_x = 11'd3; d_st[0].pos_y = 11'd5; d_st[0].mask = 4'hA; step();
        idle(); d_rv = 1; d_rw = 1; d_rtm = 4'h1; d_ra = 0; step();
        idle(); d_rv = 1; d_rw = 1; d_rtm = 4'hF; d_ra = 6; step();

        // Slot2 full: second bundle stalls, then goes through with a release.
        idle(); d_sv = 1; d_sw = 2; d_stm = 4'h5; step();
        idle(); d_sv = 1; d_sw = 2; d_stm = 4'hF; step();
        d_relv = 1; d_relw = 2; step();
        idle(); d_rv = 1; d_rw = 2; d_rtm = 4'hF; d_ra = 0; step();

        // Same-cycle write and read of wid0: old (empty) then new.
        idle(); d_sv = 1; d_sw = 0; d_stm = 4'hF; d_rv = 1; d_rw = 0; d_rtm = 4'hF; d_ra = 0; step();
        idle(); d_rv = 1; d_rw = 0; d_rtm = 4'hF; d_ra = 0; step();
        idle(); d_sv = 1; d_sw = 0; d_stm = 4'hF; d_relv = 1; d_relw = 0;
        d_rv = 1; d_rw = 0; d_rtm = 4'hF; d_ra = 12; step();
        idle(); d_rv = 1; d_rw = 0; d_rtm = 4'hF; d_ra = 12; step();

        // Out-of-range offset, partial tmask, release of an empty slot.
        idle(); d_rv = 1; d_rw = 1; d_rtm = 4'hF; d_ra = 13; step();
        idle(); d_rv = 1; d_rw = 1; d_rtm = 4'h6; d_ra = 1; step();
        idle(); d_relv = 1; d_relw = 3; step();
        idle(); step();

        // Reset with a read in flight.
        idle(); d_reset = 1; d_rv = 1; d_rw = 1; d_rtm = 4'hF; d_ra = 0; d_sv = 1; d_sw = 3; step();
        idle(); d_chk_zero = 1; step();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            idle();
            d_reset = ($urandom_range(0, 99) == 0);
            d_sv    = $urandom_range(0, 1);
            d_sw    = 2'($urandom);
            d_stm   = 4'($urandom);
            d_rv    = ($urandom_range(0, 9) < 7);
            d_rw    = 2'($urandom);
            d_rtm   = 4'($urandom);
            d_ra    = 4'($urandom_range(0, 15));
            d_relv  = ($urandom_range(0, 9) < 3);
            d_relw  = 2'($urandom);
            step();
        end

        idle();
        repeat (3) step();
        vectors++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rsp_drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
